// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Arbitrates word requests from two ports (A: datapath load/store, B: test/
// loader) onto a single-port data memory with combinational read and write
// on posedge. Each aligned request takes one ACCESS cycle on the memory. The
// owning port then receives a registered one-cycle response. A misaligned
// request is answered with an error response and never reaches the memory.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   -> round-robin between A and B when both are valid (A first
//                after reset)
//   undefined -> fixed priority, A always wins
//
// Parameters
//   byte_W : bytes per word (power of two); data width is 8*byte_W
//   Addr_W : byte-address width
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   a_req_* / b_req_*     : request handshake (valid/ready, write, addr, wdata)
//   a_resp_* / b_resp_*   : response pulse, read data, misalignment error
//   mem_address/mem_data/mem_write_enable/mem_read_data : memory port
//   busy                  : high while a memory access is in progress
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int byte_W = 4,
  parameter int Addr_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_write,
  input  logic [Addr_W-1:0]     a_req_addr,
  input  logic [8*byte_W-1:0]   a_req_wdata,
  output logic                  a_resp_valid,
  output logic [8*byte_W-1:0]   a_resp_rdata,
  output logic                  a_resp_err,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_write,
  input  logic [Addr_W-1:0]     b_req_addr,
  input  logic [8*byte_W-1:0]   b_req_wdata,
  output logic                  b_resp_valid,
  output logic [8*byte_W-1:0]   b_resp_rdata,
  output logic                  b_resp_err,
  output logic [Addr_W-1:0]     mem_address,
  output logic [8*byte_W-1:0]   mem_data,
  output logic                  mem_write_enable,
  input  logic [8*byte_W-1:0]   mem_read_data,
  output logic                  busy
);

  localparam int Data_W = 8 * byte_W;
  localparam logic [Addr_W-1:0] ALIGN_MASK = Addr_W'(byte_W - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  // Owner encoding, also used for last_grant
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [Addr_W-1:0] addr_q, addr_d;
  logic [Data_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              a_vld_q, a_vld_d, a_err_q, a_err_d;
  logic              b_vld_q, b_vld_d, b_err_q, b_err_d;
  logic [Data_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic              idle_s, access_s, grant_a_s, grant_b_s, accept_s, misaligned_s;
  logic              sel_write_s;
  logic [Addr_W-1:0] sel_addr_s;
  logic [Data_W-1:0] sel_wdata_s;

`ifdef ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
  // On contention the port that was not granted last wins
  assign grant_b_s = b_req_valid && (!a_req_valid || (last_grant_q == OWN_A));
`else
  // Fixed priority: B only gets the memory when A is idle
  assign grant_b_s = b_req_valid && !a_req_valid;
`endif
  assign grant_a_s = a_req_valid && !grant_b_s;

  // Ready is gated by rst_n so nothing is accepted while reset is held
  assign idle_s   = (state_q == S_IDLE) && rst_n;
  assign access_s = (state_q == S_ACCESS);

  assign a_req_ready = idle_s && grant_a_s;
  assign b_req_ready = idle_s && grant_b_s;
  assign accept_s    = a_req_ready || b_req_ready;

  assign sel_write_s  = grant_b_s ? b_req_write : a_req_write;
  assign sel_addr_s   = grant_b_s ? b_req_addr  : a_req_addr;
  assign sel_wdata_s  = grant_b_s ? b_req_wdata : a_req_wdata;
  assign misaligned_s = |(sel_addr_s & ALIGN_MASK);

  // Memory port is driven only during ACCESS; write is also killed by reset
  assign mem_address      = access_s ? addr_q  : {Addr_W{1'b0}};
  assign mem_data         = access_s ? wdata_q : {Data_W{1'b0}};
  assign mem_write_enable = access_s && write_q && rst_n;
  assign busy             = access_s;

  assign a_resp_valid = a_vld_q;
  assign a_resp_err   = a_err_q;
  assign a_resp_rdata = a_rdata_q;
  assign b_resp_valid = b_vld_q;
  assign b_resp_err   = b_err_q;
  assign b_resp_rdata = b_rdata_q;

  // Next-state: FSM, request latch and per-port response registers
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    a_vld_d   = 1'b0;
    a_err_d   = 1'b0;
    b_vld_d   = 1'b0;
    b_err_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          write_d = sel_write_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          owner_d = grant_b_s ? OWN_B : OWN_A;
`ifdef ROUND_ROBIN_EN
          last_grant_d = grant_b_s ? OWN_B : OWN_A;
`endif
          if (misaligned_s) begin
            // Error answered directly from IDLE; memory is never touched
            state_d = S_IDLE;
            if (grant_b_s) begin
              b_vld_d   = 1'b1;
              b_err_d   = 1'b1;
              b_rdata_d = {Data_W{1'b0}};
            end else begin
              a_vld_d   = 1'b1;
              a_err_d   = 1'b1;
              a_rdata_d = {Data_W{1'b0}};
            end
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        if (owner_q == OWN_B) begin
          b_vld_d   = 1'b1;
          b_rdata_d = write_q ? {Data_W{1'b0}} : mem_read_data;
        end else begin
          a_vld_d   = 1'b1;
          a_rdata_d = write_q ? {Data_W{1'b0}} : mem_read_data;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= {Addr_W{1'b0}};
      wdata_q   <= {Data_W{1'b0}};
      owner_q   <= OWN_A;
      a_vld_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= {Data_W{1'b0}};
      b_rdata_q <= {Data_W{1'b0}};
`ifdef ROUND_ROBIN_EN
      last_grant_q <= OWN_B;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      a_vld_q   <= a_vld_d;
      a_err_q   <= a_err_d;
      b_vld_q   <= b_vld_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for data_memory_arbiter with a small behavioural memory
// (combinational read, write on posedge). Inputs change on the falling edge
// and outputs are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  localparam int BW = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_valid, a_req_ready, a_req_write;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_resp_valid, a_resp_err;
  logic [DW-1:0] a_resp_rdata;
  logic          b_req_valid, b_req_ready, b_req_write;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_resp_valid, b_resp_err;
  logic [DW-1:0] b_resp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  logic          mem_init_n;
  logic [DW-1:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.byte_W(BW), .Addr_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata), .a_resp_err(a_resp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata), .b_resp_err(b_resp_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  // Word-indexed memory model; preload: 0x08 -> 1, 0x14 -> 3, rest 0
  always @(posedge clk) begin
    if (!mem_init_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[2] <= 32'h0000_0001;
      mem[5] <= 32'h0000_0003;
    end else if (mem_write_enable) begin
      mem[8'(mem_address >> 2)] <= mem_data;
    end
  end
  assign mem_read_data = mem[8'(mem_address >> 2)];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_req_valid = 1'b1; b_req_valid = 1'b1;
    tick(); tick();
    #1;
    total++; if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got a=%0b b=%0b want 0 0", a_req_ready, b_req_ready); end
    total++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 || a_resp_err !== 1'b0 || b_resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp: got va=%0b vb=%0b ea=%0b eb=%0b want 0", a_resp_valid, b_resp_valid, a_resp_err, b_resp_err); end
    total++; if (a_resp_rdata !== 32'h0 || b_resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got a=%h b=%h want 0", a_resp_rdata, b_resp_rdata); end
    total++; if (busy !== 1'b0 || mem_write_enable !== 1'b0 || mem_address !== 8'h0 || mem_data !== 32'h0) begin bad++; $display("FAIL rst_mem: got busy=%0b we=%0b adr=%h dat=%h want 0", busy, mem_write_enable, mem_address, mem_data); end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_read_a();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h14;
    #1;
    total++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_c0: got ra=%0b rb=%0b busy=%0b want 1 0 0", a_req_ready, b_req_ready, busy); end
    tick();
    a_req_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || a_req_ready !== 1'b0 || mem_address !== 8'h14 || mem_write_enable !== 1'b0 || a_resp_valid !== 1'b0) begin bad++; $display("FAIL rd_c1: got busy=%0b adr=%h we=%0b rv=%0b want 1 14 0 0", busy, mem_address, mem_write_enable, a_resp_valid); end
    tick(); #1;
    total++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0000_0003 || a_resp_err !== 1'b0 || busy !== 1'b0 || b_resp_valid !== 1'b0) begin bad++; $display("FAIL rd_c2: got rv=%0b rdata=%h err=%0b busy=%0b bv=%0b want 1 00000003 0 0 0", a_resp_valid, a_resp_rdata, a_resp_err, busy, b_resp_valid); end
    tick(); #1;
    total++; if (a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0000_0003) begin bad++; $display("FAIL rd_hold: got rv=%0b rdata=%h want 0 00000003", a_resp_valid, a_resp_rdata); end
  endtask

  task automatic test_misaligned();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h06;
    #1;
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL mis_ready: got %0b want 1", a_req_ready); end
    tick();
    a_req_valid = 1'b0;
    #1;
    total++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || a_resp_rdata !== 32'h0 || busy !== 1'b0 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL mis_rd: got rv=%0b err=%0b rdata=%h busy=%0b we=%0b want 1 1 0 0 0", a_resp_valid, a_resp_err, a_resp_rdata, busy, mem_write_enable); end
    // Misaligned write into the word holding 0x08
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h09; a_req_wdata = 32'hFFFF_FFFF;
    #1;
    total++; if (a_req_ready !== 1'b1 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL mis_wr_acc: got ready=%0b we=%0b want 1 0", a_req_ready, mem_write_enable); end
    tick();
    a_req_valid = 1'b0;
    #1;
    total++; if (a_resp_valid !== 1'b1 || a_resp_err !== 1'b1 || mem_write_enable !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mis_wr: got rv=%0b err=%0b we=%0b busy=%0b want 1 1 0 0", a_resp_valid, a_resp_err, mem_write_enable, busy); end
    tick(); #1;
    total++; if (mem[2] !== 32'h0000_0001 || mem[1] !== 32'h0 || a_resp_valid !== 1'b0 || a_resp_err !== 1'b0) begin bad++; $display("FAIL mis_mem: got m08=%h m04=%h rv=%0b err=%0b want 00000001 0 0 0", mem[2], mem[1], a_resp_valid, a_resp_err); end
  endtask

  task automatic test_write_read_b();
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 8'h24; b_req_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if (b_req_ready !== 1'b1 || a_req_ready !== 1'b0 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL bw_c0: got rb=%0b ra=%0b we=%0b want 1 0 0", b_req_ready, a_req_ready, mem_write_enable); end
    tick();
    b_req_valid = 1'b0; b_req_wdata = 32'h0;
    #1;
    total++; if (mem_write_enable !== 1'b1 || mem_address !== 8'h24 || mem_data !== 32'hDEAD_BEEF || b_req_ready !== 1'b0) begin bad++; $display("FAIL bw_c1: got we=%0b adr=%h dat=%h rb=%0b want 1 24 deadbeef 0", mem_write_enable, mem_address, mem_data, b_req_ready); end
    tick();
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h24;
    #1;
    total++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'h0 || b_resp_err !== 1'b0 || mem_write_enable !== 1'b0 || b_req_ready !== 1'b1 || mem[9] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bw_ack: got bv=%0b rdata=%h err=%0b we=%0b rb=%0b mem=%h want 1 0 0 0 1 deadbeef", b_resp_valid, b_resp_rdata, b_resp_err, mem_write_enable, b_req_ready, mem[9]); end
    tick();
    b_req_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || mem_write_enable !== 1'b0 || b_resp_valid !== 1'b0) begin bad++; $display("FAIL br_c1: got busy=%0b we=%0b bv=%0b want 1 0 0", busy, mem_write_enable, b_resp_valid); end
    tick(); #1;
    total++; if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'hDEAD_BEEF || b_resp_err !== 1'b0 || a_resp_valid !== 1'b0) begin bad++; $display("FAIL br_data: got bv=%0b rdata=%h err=%0b av=%0b want 1 deadbeef 0 0", b_resp_valid, b_resp_rdata, b_resp_err, a_resp_valid); end
    tick();
  endtask

  task automatic test_arbitration();
    logic ea, eb, eab;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h00;
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'h04;
    for (int i = 0; i < 8; i++) begin
`ifdef ROUND_ROBIN_EN
      // last grant before this test was B, so A wins first
      ea = ((i % 4) == 0);
      eb = ((i % 4) == 2);
`else
      ea = ((i % 2) == 0);
      eb = 1'b0;
`endif
      eab = ((i % 2) == 1);
      #1;
      total++; if (a_req_ready !== ea || b_req_ready !== eb || busy !== eab) begin bad++; $display("FAIL arb_c%0d: got ra=%0b rb=%0b busy=%0b want %0b %0b %0b", i, a_req_ready, b_req_ready, busy, ea, eb, eab); end
      tick();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_access();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h14;
    tick();
    a_req_valid = 1'b0;
    tick();
    #1;
    total++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'h0000_0003) begin bad++; $display("FAIL ra_pre: got rv=%0b rdata=%h want 1 00000003", a_resp_valid, a_resp_rdata); end
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h08; a_req_wdata = 32'h1234_5678;
    tick();
    a_req_valid = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || mem_write_enable !== 1'b1 || mem_address !== 8'h08) begin bad++; $display("FAIL ra_acc: got busy=%0b we=%0b adr=%h want 1 1 08", busy, mem_write_enable, mem_address); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_write_enable !== 1'b0) begin bad++; $display("FAIL ra_gate: got we=%0b want 0", mem_write_enable); end
    tick();
    #1;
    total++; if (mem[2] !== 32'h0000_0001 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0 || busy !== 1'b0 || mem_address !== 8'h0 || mem_data !== 32'h0 || mem_write_enable !== 1'b0) begin bad++; $display("FAIL ra_post: got m08=%h rv=%0b rdata=%h busy=%0b adr=%h dat=%h we=%0b want 00000001 0 0 0 0 0 0", mem[2], a_resp_valid, a_resp_rdata, busy, mem_address, mem_data, mem_write_enable); end
    rst_n = 1'b1;
    tick(); #1;
    total++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 || busy !== 1'b0 || mem[2] !== 32'h0000_0001) begin bad++; $display("FAIL ra_late: got av=%0b bv=%0b busy=%0b m08=%h want 0 0 0 00000001", a_resp_valid, b_resp_valid, busy, mem[2]); end
  endtask

  initial begin
    rst_n = 1'b0; mem_init_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h0; a_req_wdata = 32'h0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h0; b_req_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    mem_init_n = 1'b1;
    test_reset();
    test_read_a();
    test_misaligned();
    test_write_read_b();
    test_arbitration();
    test_reset_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory (combinational read, write on posedge). It accepts word requests from the datapath load/store port (A) and the test/loader port (B) and serializes them onto the memory port. It returns registered read data and write acknowledgements, and rejects misaligned addresses without touching memory.

## Interface
- byte_W, 4: bytes per word; must be a power of two; sets data width 8*byte_W.
- Addr_W, 8: byte-address width, matching the memory's address port.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- a_req_valid  in  1  port A request present.
- a_req_ready  out  1  port A request accepted this cycle when high with a_req_valid.
- a_req_write  in  1  1 = write, 0 = read.
- a_req_addr  in  Addr_W  byte address.
- a_req_wdata  in  8*byte_W  write data.
- a_resp_valid  out  1  one-cycle response pulse.
- a_resp_rdata  out  8*byte_W  read data; 0 for writes and errors.
- a_resp_err  out  1  misaligned request; qualified by a_resp_valid.
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_wdata, b_resp_valid, b_resp_rdata, b_resp_err: identical to the port A signals, for port B.
- mem_address  out  Addr_W  to memory inp_address.
- mem_data  out  8*byte_W  to memory inp_data.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_data  in  8*byte_W  from memory out_read_data.
- busy  out  1  high while in ACCESS.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: select a winner from the valid requesters and assert ready to the winner only. On valid&&ready:
  - latch write, addr, wdata and owner;
  - aligned (addr mod byte_W == 0) -> go to ACCESS;
  - misaligned -> stay in IDLE, no memory access, error response next cycle.
- ACCESS (exactly one cycle):
  - mem_address = latched addr; mem_data = latched wdata; mem_write_enable = latched write && rst_n;
  - reads capture mem_read_data into the owner's rdata register at the closing edge;
  - writes commit at the same edge;
  - next state IDLE.
- Response: the owner's resp_valid pulses high for exactly one cycle, the cycle after ACCESS or after a misaligned accept. It coincides with IDLE, so a new accept may occur in that same cycle.
- No backpressure on responses; requesters must sample resp_* on the pulse.
- rdata holds its value until that port's next response. Writes and errors load rdata = 0.
- Outside ACCESS: mem_write_enable = 0, mem_address = 0, mem_data = 0.
- Address wrap: addr + byte_W - 1 is not checked; aligned top addresses are passed through unchanged.
- Requests need not be held stable after acceptance; a deasserted valid before acceptance is legal and drops the request.

## Timing
- Read latency: accept at edge N, ACCESS in cycle N+1, resp_valid in cycle N+2 with data.
- Write: memory updated at the edge ending cycle N+1; ack in cycle N+2.
- Misaligned: error response in cycle N+1.
- Throughput: one aligned transaction per 2 cycles; ready is low throughout ACCESS.
- Reset values: state IDLE; all ready, resp_valid, resp_err, busy, mem_write_enable = 0; rdata = 0; mem_address and mem_data = 0; last_grant = B.
- Reset asserted during ACCESS: the write is suppressed (write_enable gated by rst_n), no response is issued, and the in-flight transaction is lost.

## Configuration
- ROUND_ROBIN_EN defined: when both ports are valid in IDLE, the port not granted last wins. last_grant updates on every accept, including misaligned ones. After reset A wins first.
- ROUND_ROBIN_EN undefined: fixed priority, A always wins; B is served only when A is not valid. last_grant logic is removed.

## Test plan
- A read 0x14 after reset, memory holding 0x00000003 there -> a_req_ready in cycle 0, busy in cycle 1, a_resp_valid in cycle 2 with a_resp_rdata = 0x00000003, a_resp_err = 0.
- B write 0x24 with 0xDEADBEEF, then B read 0x24 -> write ack with rdata = 0; read returns 0xDEADBEEF; mem_write_enable high for exactly one cycle.
- A and B both valid continuously for reads of 0x00/0x04 -> with ROUND_ROBIN_EN, grants alternate A,B,A,B, one per 2 cycles; without it, A only and B starves.
- A read 0x06 -> a_resp_valid with a_resp_err = 1 in the next cycle, mem_write_enable never asserted, and memory contents unchanged.
- A write 0x08 with rst_n driven low during ACCESS -> memory word at 0x08 unchanged (0x00000001), no a_resp_valid, all outputs at reset values afterwards.
